// File: rtl/usb_uart_bridge_pkg.sv
// Shared state encodings and defaults for the usb_serial <-> 8N1 UART bridge.
package usb_uart_bridge_pkg;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // 48 MHz / 417 is within 0.1% of 115200 baud.
  localparam int unsigned BAUD_DIV_115200 = 417;

endpackage

// File: rtl/bridge_fifo.sv
// Show-ahead synchronous FIFO; a push while full is accepted when a pop happens on the same edge.
module bridge_fifo #(
  parameter int WIDTH = 8,
  parameter int LOG2  = 4
) (
  input  logic             clk_48mhz,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  logic [LOG2:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0]   mem [0:(1<<LOG2)-1];
  logic               do_pop, do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[LOG2] != rd_ptr[LOG2]) && (wr_ptr[LOG2-1:0] == rd_ptr[LOG2-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[LOG2-1:0]];

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (LOG2+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (LOG2+1)'(1);
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (do_push) mem[wr_ptr[LOG2-1:0]] <= din;
  end

endmodule

// File: rtl/usb_uart_bridge.sv
// Full-duplex usb_serial byte interface <-> 8N1 UART bridge with per-direction FIFOs,
// a power-up quiet period and an internal loopback path.
module usb_uart_bridge
  import usb_uart_bridge_pkg::*;
#(
  parameter int BAUD_DIV     = BAUD_DIV_115200,
  parameter int FIFO_LOG2    = 4,
  parameter int STARTUP_LOG2 = 20
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic       loopback,
  input  logic       host_rx_valid,
  input  logic [7:0] host_rx_data,
  output logic       host_rx_ack,
  input  logic       host_tx_ready,
  output logic [7:0] host_tx_data,
  output logic       host_tx_strobe,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic       active,
  output logic       rx_overflow,
  output logic       rx_frame_err
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  // ---------------- startup quiet period ----------------
  logic [STARTUP_LOG2-1:0] quiet_cnt;

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      quiet_cnt <= '0;
      active    <= 1'b0;
    end else if (!active) begin
      quiet_cnt <= quiet_cnt + STARTUP_LOG2'(1);
      if (&quiet_cnt) active <= 1'b1;
    end
  end

  // ---------------- FIFOs ----------------
  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0] tx_dout;
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] rx_dout, rx_shift;

  bridge_fifo #(.WIDTH(8), .LOG2(FIFO_LOG2)) u_tx_fifo (
    .clk_48mhz(clk_48mhz), .reset(reset), .push(tx_push), .din(host_rx_data),
    .pop(tx_pop), .full(tx_full), .empty(tx_empty), .dout(tx_dout));

  bridge_fifo #(.WIDTH(8), .LOG2(FIFO_LOG2)) u_rx_fifo (
    .clk_48mhz(clk_48mhz), .reset(reset), .push(rx_push), .din(rx_shift),
    .pop(rx_pop), .full(rx_full), .empty(rx_empty), .dout(rx_dout));

  // ---------------- host handshakes ----------------
  // Gating on the previous pulse forces an idle cycle between acks/strobes.
  assign tx_push = active & host_rx_valid & ~tx_full & ~host_rx_ack;
  assign rx_pop  = active & host_tx_ready & ~rx_empty & ~host_tx_strobe;

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      host_rx_ack    <= 1'b0;
      host_tx_strobe <= 1'b0;
      host_tx_data   <= '0;
    end else begin
      host_rx_ack    <= tx_push;
      host_tx_strobe <= rx_pop;
      if (rx_pop) host_tx_data <= rx_dout;
    end
  end

  // ---------------- TX serializer ----------------
  tx_state_e   tx_state, tx_state_nx;
  logic [CW-1:0] tx_cnt;
  logic [2:0]  tx_idx;
  logic [7:0]  tx_shift;
  logic        tx_tick, tx_bit;

  assign tx_tick = (tx_cnt == BAUD_LAST);

  always_comb begin
    tx_state_nx = tx_state;
    tx_pop      = 1'b0;
    tx_bit      = 1'b1;
    case (tx_state)
      TX_IDLE: if (active && !tx_empty) begin
        tx_pop      = 1'b1;
        tx_state_nx = TX_START;
      end
      TX_START: begin
        tx_bit = 1'b0;
        if (tx_tick) tx_state_nx = TX_DATA;
      end
      TX_DATA: begin
        tx_bit = tx_shift[0];
        if (tx_tick && tx_idx == 3'd7) tx_state_nx = TX_STOP;
      end
      TX_STOP: if (tx_tick) begin
        // Chain straight into the next frame so queued bytes go out with no idle gap.
        if (!tx_empty) begin
          tx_pop      = 1'b1;
          tx_state_nx = TX_START;
        end else begin
          tx_state_nx = TX_IDLE;
        end
      end
      default: tx_state_nx = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
    end else begin
      tx_state <= tx_state_nx;
      tx_cnt   <= (tx_state == TX_IDLE || tx_tick) ? '0 : tx_cnt + CW'(1);
      if (tx_pop) tx_shift <= tx_dout;
      if (tx_state == TX_DATA && tx_tick) begin
        tx_shift <= {1'b0, tx_shift[7:1]};
        tx_idx   <= tx_idx + 3'd1;
      end
    end
  end

  // ---------------- RX deserializer ----------------
  rx_state_e   rx_state, rx_state_nx;
  logic [CW-1:0] rx_cnt;
  logic [2:0]  rx_idx;
  logic        loopback_q, rx_src, rx_sync1, rx_sync2, rx_prev;
  logic        rx_tick, rx_half, rx_stop_sample;

  assign rx_src         = loopback_q ? tx_bit : uart_rxd;
  assign uart_txd       = loopback_q ? 1'b1 : tx_bit;
  assign rx_tick        = (rx_cnt == BAUD_LAST);
  assign rx_half        = (rx_cnt == HALF_LAST);
  assign rx_stop_sample = (rx_state == RX_STOP) && rx_tick;
  assign rx_push        = rx_stop_sample & rx_sync2;

  always_comb begin
    rx_state_nx = rx_state;
    case (rx_state)
      RX_IDLE:  if (active && !rx_sync2 && rx_prev) rx_state_nx = RX_START;
      RX_START: if (rx_half) rx_state_nx = rx_sync2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_idx == 3'd7) rx_state_nx = RX_STOP;
      RX_STOP:  if (rx_tick) rx_state_nx = RX_IDLE;
      default:  rx_state_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      rx_state     <= RX_IDLE;
      rx_cnt       <= '0;
      rx_idx       <= '0;
      rx_shift     <= '0;
      rx_sync1     <= 1'b1;
      rx_sync2     <= 1'b1;
      rx_prev      <= 1'b1;
      loopback_q   <= 1'b0;
      rx_overflow  <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_sync1 <= rx_src;
      rx_sync2 <= rx_sync1;
      rx_prev  <= rx_sync2;
      rx_state <= rx_state_nx;
      // Restarting at the half-bit check puts every later sample at mid-bit.
      rx_cnt   <= (rx_state == RX_IDLE || (rx_state == RX_START && rx_half) || rx_tick)
                  ? '0 : rx_cnt + CW'(1);
      if (rx_state == RX_DATA && rx_tick) begin
        rx_shift <= {rx_sync2, rx_shift[7:1]};
        rx_idx   <= rx_idx + 3'd1;
      end
      if (rx_stop_sample && rx_sync2 && rx_full && !rx_pop) rx_overflow  <= 1'b1;
      if (rx_stop_sample && !rx_sync2)                      rx_frame_err <= 1'b1;
      if (tx_state == TX_IDLE && rx_state == RX_IDLE) loopback_q <= loopback;
    end
  end

endmodule

// File: tb/tb_usb_uart_bridge.sv
// Scoreboard bench for usb_uart_bridge: stimulus pushes expected bytes, monitors pop and compare.
module tb_usb_uart_bridge;
  localparam int BD = 4;
  localparam int FL = 2;
  localparam int SL = 4;

  logic       clk_48mhz = 1'b0;
  logic       reset = 1'b1;
  logic       loopback = 1'b0;
  logic       host_rx_valid = 1'b0;
  logic [7:0] host_rx_data = 8'h00;
  logic       host_rx_ack;
  logic       host_tx_ready;
  logic [7:0] host_tx_data;
  logic       host_tx_strobe;
  logic       uart_rxd = 1'b1;
  logic       uart_txd, active, rx_overflow, rx_frame_err;

  logic ready_main = 1'b0, ready_rnd = 1'b0, rand_ready = 1'b0;
  assign host_tx_ready = rand_ready ? ready_rnd : ready_main;

  always #5 clk_48mhz = ~clk_48mhz;

  usb_uart_bridge #(.BAUD_DIV(BD), .FIFO_LOG2(FL), .STARTUP_LOG2(SL)) dut (
    .clk_48mhz(clk_48mhz), .reset(reset), .loopback(loopback),
    .host_rx_valid(host_rx_valid), .host_rx_data(host_rx_data), .host_rx_ack(host_rx_ack),
    .host_tx_ready(host_tx_ready), .host_tx_data(host_tx_data), .host_tx_strobe(host_tx_strobe),
    .uart_rxd(uart_rxd), .uart_txd(uart_txd), .active(active),
    .rx_overflow(rx_overflow), .rx_frame_err(rx_frame_err));

  int total = 0;
  int bad = 0;
  int acks = 0;
  int txd_low = 0;
  logic lb_watch = 1'b0;
  logic [7:0] exp_uart[$];
  logic [7:0] exp_host[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // UART line receiver: decode frames at mid-bit and match against the expected queue.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk_48mhz);
      if (uart_txd === 1'b0) begin
        repeat (BD/2) @(negedge clk_48mhz);
        chk("uart start bit", {31'd0, uart_txd}, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk_48mhz);
          b[i] = uart_txd;
        end
        repeat (BD) @(negedge clk_48mhz);
        chk("uart stop bit", {31'd0, uart_txd}, 1);
        if (exp_uart.size() == 0) chk("uart unexpected byte", {24'd0, b}, 32'hFFFF_FFFF);
        else chk("uart byte", {24'd0, b}, {24'd0, exp_uart.pop_front()});
      end
    end
  end

  // Host-bound monitor.
  initial begin
    forever begin
      @(negedge clk_48mhz);
      if (host_tx_strobe === 1'b1) begin
        if (exp_host.size() == 0) chk("host unexpected strobe", {24'd0, host_tx_data}, 32'hFFFF_FFFF);
        else chk("host byte", {24'd0, host_tx_data}, {24'd0, exp_host.pop_front()});
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_48mhz);
      if (rand_ready) ready_rnd = 1'($urandom_range(0, 1));
      if (lb_watch && uart_txd !== 1'b1) txd_low++;
    end
  end

  task automatic host_send(input logic [7:0] d, input bit to_host);
    bit got = 0;
    host_rx_valid = 1'b1;
    host_rx_data  = d;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk_48mhz);
      if (host_rx_ack) got = 1;
    end
    chk("host ack", {31'd0, got}, 1);
    if (got) begin
      acks++;
      if (to_host) exp_host.push_back(d);
      else exp_uart.push_back(d);
    end
    host_rx_valid = 1'b0;
  endtask

  task automatic uart_send(input logic [7:0] d, input bit stop, input bit expect_push);
    uart_rxd = 1'b0;
    repeat (BD) @(negedge clk_48mhz);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      repeat (BD) @(negedge clk_48mhz);
    end
    uart_rxd = stop;
    if (expect_push) exp_host.push_back(d);
    repeat (BD) @(negedge clk_48mhz);
    uart_rxd = 1'b1;
    repeat (BD) @(negedge clk_48mhz);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 3000 && (exp_uart.size() + exp_host.size()) != 0; i++)
      @(negedge clk_48mhz);
    chk(name, exp_uart.size() + exp_host.size(), 0);
    repeat (8) @(negedge clk_48mhz);
  endtask

  initial begin
    int viol;
    int base;
    logic [7:0] b41;
    logic exp_bit;

    // Reset state
    repeat (3) @(negedge clk_48mhz);
    chk("reset ack", {31'd0, host_rx_ack}, 0);
    chk("reset strobe", {31'd0, host_tx_strobe}, 0);
    chk("reset tx data", {24'd0, host_tx_data}, 0);
    chk("reset txd", {31'd0, uart_txd}, 1);
    chk("reset active", {31'd0, active}, 0);
    chk("reset flags", {30'd0, rx_overflow, rx_frame_err}, 0);

    // Quiet period: 2^SL cycles with no ack, then the first ack
    host_rx_valid = 1'b1;
    host_rx_data  = 8'h41;
    reset = 1'b0;
    viol = 0;
    for (int n = 1; n <= (1 << SL); n++) begin
      @(negedge clk_48mhz);
      if (host_rx_ack !== 1'b0 || active !== (n >= (1 << SL))) viol++;
    end
    chk("quiet period", viol, 0);
    chk("active rises", {31'd0, active}, 1);
    @(negedge clk_48mhz);
    chk("first ack", {31'd0, host_rx_ack}, 1);
    exp_uart.push_back(8'h41);
    acks++;
    host_rx_valid = 1'b0;

    // Exact bit timing of 0x41: start, LSB-first data, stop, BD cycles each
    b41 = 8'h41;
    viol = 0;
    for (int k = 0; k < 10 * BD; k++) begin
      @(negedge clk_48mhz);
      if (k < BD) exp_bit = 1'b0;
      else if (k < 9 * BD) exp_bit = b41[(k - BD) / BD];
      else exp_bit = 1'b1;
      if (uart_txd !== exp_bit) viol++;
    end
    chk("0x41 waveform", viol, 0);
    wait_drain("0x41 drained");

    // Single UART byte to host
    ready_main = 1'b1;
    uart_send(8'h5A, 1'b1, 1'b1);
    wait_drain("0x5A delivered");
    chk("flags after 0x5A", {30'd0, rx_overflow, rx_frame_err}, 0);

    // Host streams 6 bytes: one in flight plus a full FIFO, then backpressure
    base = acks;
    fork
      for (int i = 0; i < 6; i++) host_send(8'h10 + 8'(i), 1'b0);
    join_none
    repeat (20) @(negedge clk_48mhz);
    chk("acks before drain", acks - base, (1 << FL) + 1);
    for (int i = 0; i < 500 && acks - base < 6; i++) @(negedge clk_48mhz);
    chk("all 6 acked", acks - base, 6);
    wait_drain("stream drained");

    // Loopback
    loopback = 1'b1;
    lb_watch = 1'b1;
    repeat (2) @(negedge clk_48mhz);
    host_send(8'h00, 1'b1);
    host_send(8'hFF, 1'b1);
    host_send(8'h55, 1'b1);
    wait_drain("loopback echoed");
    lb_watch = 1'b0;
    chk("loopback txd idle", txd_low, 0);
    loopback = 1'b0;
    repeat (20) @(negedge clk_48mhz);

    // Randomized traffic in both directions with a random host_tx_ready
    rand_ready = 1'b1;
    fork
      for (int i = 0; i < 8; i++) host_send(8'($urandom), 1'b0);
      for (int i = 0; i < 6; i++) begin
        uart_send(8'($urandom), 1'b1, 1'b1);
        repeat ($urandom_range(0, 10)) @(negedge clk_48mhz);
      end
    join
    wait_drain("random drained");
    rand_ready = 1'b0;

    // Framing error then recovery
    uart_send(8'h33, 1'b0, 1'b0);
    repeat (10) @(negedge clk_48mhz);
    chk("frame err set", {31'd0, rx_frame_err}, 1);
    chk("no overflow yet", {31'd0, rx_overflow}, 0);
    uart_send(8'hC3, 1'b1, 1'b1);
    wait_drain("byte after frame err");

    // Overflow: host not ready, FIFO depth + 1 bytes
    ready_main = 1'b0;
    for (int i = 0; i < (1 << FL); i++) uart_send(8'($urandom), 1'b1, 1'b1);
    chk("overflow clear when full", {31'd0, rx_overflow}, 0);
    uart_send(8'hEE, 1'b1, 1'b0);
    chk("overflow set", {31'd0, rx_overflow}, 1);
    ready_main = 1'b1;
    wait_drain("overflow survivors");

    // Reset mid-frame: flags clear, partial frame discarded, quiet period restarts
    fork
      uart_send(8'hFF, 1'b1, 1'b0);
    join_none
    repeat (10) @(negedge clk_48mhz);
    reset = 1'b1;
    @(negedge clk_48mhz);
    reset = 1'b0;
    chk("mid reset active", {31'd0, active}, 0);
    chk("mid reset flags", {30'd0, rx_overflow, rx_frame_err}, 0);
    chk("mid reset txd", {31'd0, uart_txd}, 1);
    repeat (80) @(negedge clk_48mhz);
    chk("active again", {31'd0, active}, 1);
    chk("queues empty", exp_uart.size() + exp_host.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
